// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, packet field positions, route function.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package noc_pkg;

  localparam int NPORTS  = 5;
  localparam int P_LOCAL = 0;
  localparam int P_UP    = 1;
  localparam int P_DOWN  = 2;
  localparam int P_LEFT  = 3;
  localparam int P_RIGHT = 4;

  // Destination coordinate fields inside a packet
  localparam int X_MSB = 36;
  localparam int X_LSB = 33;
  localparam int Y_MSB = 32;
  localparam int Y_LSB = 29;

  typedef logic [2:0] port_t;

  // Y-first dimension-order route with shortest-path wrap; ties go Down/Right.
  // Only meaningful for legal destinations (x < x_dim, y < y_dim).
  function automatic port_t route_dir(input logic [3:0] x, input logic [3:0] y,
                                      input int x_local, input int y_local,
                                      input int x_dim, input int y_dim);
    int dx;
    int dy;
    dy = (int'(y) - y_local + y_dim) % y_dim;
    dx = (int'(x) - x_local + x_dim) % x_dim;
    if (dy != 0)
      route_dir = (dy <= y_dim / 2) ? port_t'(P_DOWN) : port_t'(P_UP);
    else if (dx != 0)
      route_dir = (dx <= x_dim / 2) ? port_t'(P_RIGHT) : port_t'(P_LEFT);
    else
      route_dir = port_t'(P_LOCAL);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with full/empty/count; head is visible combinationally.
// Latency: a push at edge k is readable as head after edge k.
// Backpressure: pushes are ignored while full, even if a pop happens in the same cycle.
module noc_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/torus_router.sv
// Five-port torus router node: input FIFOs, Y-first shortest-path routing, round-robin registered outputs.
// Latency: 1 cycle from input accept to out_valid when the output is free and uncontended.
// Backpressure: out_ready low holds the output register; FIFOs fill and in_ready drops when full.
module torus_router
  import noc_pkg::*;
#(
  parameter int WIDTH   = 39,
  parameter int X_DIM   = 4,
  parameter int Y_DIM   = 5,
  parameter int X_LOCAL = 0,
  parameter int Y_LOCAL = 1,
  parameter int DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS-1:0][WIDTH-1:0]   in_data,
  input  logic [NPORTS-1:0]              in_valid,
  output logic [NPORTS-1:0]              in_ready,
  output logic [NPORTS-1:0][WIDTH-1:0]   out_data,
  output logic [NPORTS-1:0]              out_valid,
  input  logic [NPORTS-1:0]              out_ready,
  output logic [7:0]                     drop_cnt
);

  logic [NPORTS-1:0][WIDTH-1:0]       head;
  logic [NPORTS-1:0]                  fifo_full;
  logic [NPORTS-1:0]                  fifo_empty;
  logic [NPORTS-1:0][$clog2(DEPTH):0] fifo_count;
  logic [NPORTS-1:0]                  illegal;
  logic [NPORTS-1:0]                  drop_pop;
  logic [NPORTS-1:0]                  pop;
  port_t [NPORTS-1:0]                 dir;
  logic [NPORTS-1:0][NPORTS-1:0]      req;   // [output][input]
  logic [NPORTS-1:0][NPORTS-1:0]      gnt;   // [output][input]
  logic [8:0]                         drop_sum;
  logic                               unused_count;

  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[i]),
      .push_data (in_data[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .count     (fifo_count[i])
    );
    assign in_ready[i] = !fifo_full[i];
  end

  // Occupancy is kept on the FIFO for observability; flow control uses full/empty
  assign unused_count = ^fifo_count;

  // Route each FIFO head; an illegal head is dropped, a legal one requests exactly one output
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      illegal[i]  = (int'(head[i][X_MSB:X_LSB]) >= X_DIM) || (int'(head[i][Y_MSB:Y_LSB]) >= Y_DIM);
      dir[i]      = route_dir(head[i][X_MSB:X_LSB], head[i][Y_MSB:Y_LSB], X_LOCAL, Y_LOCAL, X_DIM, Y_DIM);
      drop_pop[i] = !fifo_empty[i] && illegal[i];
      for (int o = 0; o < NPORTS; o++)
        req[o][i] = !fifo_empty[i] && !illegal[i] && (dir[i] == port_t'(o));
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [2:0]        rr_ptr;
    logic              stage_free;
    logic [NPORTS-1:0] grant;
    logic [2:0]        grant_idx;
    logic [2:0]        idx;
    logic              vld_q;
    logic [WIDTH-1:0]  dat_q;

    assign stage_free   = !vld_q || out_ready[o];
    assign gnt[o]       = grant;
    assign out_valid[o] = vld_q;
    assign out_data[o]  = dat_q;

    // Round-robin search from the pointer; grants only when the stage can load this cycle
    always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      for (int k = 0; k < NPORTS; k++) begin
        idx = 3'((int'(rr_ptr) + k) % NPORTS);
        if (stage_free && (grant == '0) && req[o][idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end

    // Output register refills in the same cycle it drains; pointer moves past the winner
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        dat_q  <= '0;
        rr_ptr <= '0;
      end else if (stage_free) begin
        vld_q <= |grant;
        if (|grant) begin
          dat_q  <= head[grant_idx];
          rr_ptr <= (grant_idx == 3'(NPORTS - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
      end
    end
  end

  // A FIFO pops when any output grants it or when its head is being dropped
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      pop[i] = drop_pop[i];
      for (int o = 0; o < NPORTS; o++)
        pop[i] = pop[i] | gnt[o][i];
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 9'($countones(drop_pop));

  // Saturating count of dropped packets; several ports may drop in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

endmodule

// File: doc/torus_router.md
# torus_router

Clocked, parametrised successor to the per-direction torus switches. One 5-port router node (Local, Up, Down, Left, Right) with an input FIFO per port, Y-first dimension-order routing with shortest-path wrap-around on both axes, and a round-robin arbiter plus registered output stage per port. Tiles into an X_DIM × Y_DIM torus, with valid/ready links between neighbours. The local port connects to the PE.

## Interface
- WIDTH, 39, packet width; dest x = [36:33], dest y = [32:29]
- X_DIM, 4, torus columns (2..16)
- Y_DIM, 5, torus rows (2..16)
- X_LOCAL, 0, this node's column (< X_DIM)
- Y_LOCAL, 1, this node's row (< Y_DIM)
- DEPTH, 4, input FIFO entries per port, power of 2, ≥ 2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  5×WIDTH  input packet per port; index 0 L, 1 U, 2 D, 3 Lf, 4 R
- in_valid  in  5  input packet present
- in_ready  out  5  input FIFO can accept
- out_data  out  5×WIDTH  output packet per port, same index order
- out_valid  out  5  output register holds a packet
- out_ready  in  5  downstream accepts
- drop_cnt  out  8  saturating count of packets dropped for an illegal destination

## Operation
- Transfer on a port happens when valid && ready at a rising edge. Data is stable while valid && !ready.
- in_ready[p] = !full[p], taken from the registered count. A full FIFO never accepts, even if it pops in the same cycle.
- Route computation on each FIFO head, combinational from the head packet:
  - dy = (y − Y_LOCAL) mod Y_DIM; dx = (x − X_LOCAL) mod X_DIM.
  - dy ≠ 0: route Down if dy ≤ Y_DIM/2 (floor), else Up.
  - dy = 0, dx ≠ 0: route Right if dx ≤ X_DIM/2, else Left.
  - dy = 0 and dx = 0: route Local.
  - Ties go Down or Right. U-turns are permitted.
- Illegal destination (x ≥ X_DIM or y ≥ Y_DIM): the head is popped without forwarding, and drop_cnt increments and saturates at 255.
- Output stage per port: one WIDTH register plus a valid bit.
  - The stage is free when !out_valid or out_ready, so it refills in the same cycle it drains.
  - When free, the round-robin arbiter grants one requesting FIFO head. That head is popped and loaded.
- Round-robin: a separate pointer per output. After a grant to input i, the pointer moves to i+1 mod 5, and the search starts from the pointer. With no grant the pointer is unchanged.
- A FIFO head requests exactly one output, so each input pops at most once per cycle. No packet is duplicated or reordered per input→output pair.

## Timing
- Reset (async assert, sync release): FIFOs empty, in_ready = 5'b11111, out_valid = 0, out_data = 0, arbiter pointers = 0, drop_cnt = 0.
- Minimum latency: a packet accepted at edge k gives out_valid high after edge k+1 (1 cycle) when the output is free and uncontended.
- Sustained throughput is 1 packet/cycle/output with out_ready held high.
- Back-pressure: while out_ready is low, out_valid/out_data hold and the FIFO fills. in_ready drops the cycle after count reaches DEPTH.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both occur.
- Reset asserted mid-transfer discards all buffered and output packets immediately. No partial state survives.

## Structure
- Shared package `noc_pkg` holds:
  - port index constants (P_LOCAL = 0, P_UP, P_DOWN, P_LEFT, P_RIGHT)
  - field positions for x and y
  - `route_dir()` function(x, y, X_LOCAL, Y_LOCAL, X_DIM, Y_DIM)
- Sub-module `noc_fifo`: parametrised WIDTH/DEPTH synchronous FIFO with full/empty/count, instantiated 5×.
- Arbiters, output registers and drop counter are inline generate loops in the top module.

## Test plan
Bench uses X_DIM = 4, Y_DIM = 5, X_LOCAL = 1, Y_LOCAL = 1.
- Reset then idle: in_ready = 5'b11111, out_valid = 0, drop_cnt = 0. Assert rst_n low mid-traffic: out_valid drops immediately.
- Single packets on port L:
  - dest (1,1) → out L after 1 cycle.
  - (1,3) → Down.
  - (1,4) → Up (wrap).
  - (3,1) → Right (tie).
  - (0,1) → Left.
  - (2,4) → Up (Y first).
- Contention: inputs U, D, Lf, R each stream 3 packets to (1,1) with out_ready = 1. Out L grants in rotation U, D, Lf, R, U… with 12 packets delivered in 12 consecutive cycles.
- Back-pressure: out_ready[Down] = 0, send 6 packets on L to (1,3).
  - in_ready[0] falls after 5 accepts (4 in FIFO + 1 in output register).
  - Releasing out_ready delivers all 6 in order.
- Illegal dest (5,0) on port R: not forwarded on any output, drop_cnt = 1. After 300 such packets, drop_cnt = 255.
- Random traffic at 50% out_ready for 10k packets: every legal packet appears exactly once on its computed port, with per-input order preserved.
